// File: rtl/tqvp_fir_seq_pkg.sv
// Shared constants and types for the tqvp_fir_seq FIR sequencer.
package tqvp_fir_seq_pkg;

    localparam int unsigned NTAPS = 4;
    localparam int unsigned ACC_W = 18;

    // Register map
    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_DIV    = 4'h1;
    localparam logic [3:0] ADDR_COEF0  = 4'h2;
    localparam logic [3:0] ADDR_COEF1  = 4'h3;
    localparam logic [3:0] ADDR_COEF2  = 4'h4;
    localparam logic [3:0] ADDR_COEF3  = 4'h5;
    localparam logic [3:0] ADDR_SHIFT  = 4'h6;
    localparam logic [3:0] ADDR_RESULT = 4'h7;
    localparam logic [3:0] ADDR_STATUS = 4'h8;

    // CTRL bits
    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_TRIG = 1;
    localparam int unsigned CTRL_CLR  = 2;

    // STATUS bits
    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_VALID = 1;
    localparam int unsigned STAT_OVR   = 2;
    localparam int unsigned STAT_WERR  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StDone
    } fir_state_e;

endpackage

// File: rtl/tqvp_fir_seq_mac.sv
// Shared multiply-accumulate: unsigned 8-bit sample times signed 8-bit coefficient,
// accumulated into an 18-bit signed register.
module tqvp_fir_seq_mac
    import tqvp_fir_seq_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    acc_en,
    input  logic [7:0]              sample,
    input  logic [7:0]              coef,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [16:0]      sample_x;
    logic signed [16:0]      coef_x;
    logic signed [16:0]      prod;
    logic signed [ACC_W-1:0] acc_q;

    // Sample is zero-extended (unsigned), coefficient sign-extended.
    assign sample_x = {9'b0, sample};
    assign coef_x   = {{9{coef[7]}}, coef};
    assign prod     = sample_x * coef_x;
    assign acc      = acc_q;

    // Accumulator; clear wins so a new run always starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (acc_en) begin
            acc_q <= acc_q + {prod[16], prod};
        end
    end

endmodule

// File: rtl/tqvp_fir_seq.sv
// tqvp_fir_seq: register-programmable 4-tap FIR sequencer for the TinyQV byte-peripheral slot.
// Optional: define TQVP_FIR_SEQ_SATURATE_EN to clamp RESULT to 0..255 instead of truncating.
module tqvp_fir_seq #(
    parameter int unsigned NTAPS     = 4,
    parameter logic [7:0]  RESET_DIV = 8'd63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    import tqvp_fir_seq_pkg::*;

    localparam int unsigned TapW = $clog2(NTAPS);

    fir_state_e              state_q, state_d;
    logic [TapW-1:0]         tap_q, tap_d;
    logic                    en_q, trig_q;
    logic [7:0]              div_q, cnt_q;
    logic [7:0]              coef_q [NTAPS];
    logic [7:0]              hist_q [NTAPS];
    logic [2:0]              shift_q;
    logic [7:0]              result_q, result_d;
    logic                    valid_q, ovr_q, werr_q;
    logic signed [ACC_W-1:0] acc;
    logic [TapW-1:0]         coef_idx;
    logic [7:0]              status;
    logic busy, wr_ctrl, wr_div, wr_cfg, wr_status, clr;
    logic div_tick, tick, tick_go, tick_ovr;
    logic mac_clr, mac_en, load_result;

    assign busy      = (state_q != StIdle);
    assign wr_ctrl   = data_write && (address == ADDR_CTRL);
    assign wr_div    = data_write && (address == ADDR_DIV);
    assign wr_status = data_write && (address == ADDR_STATUS);
    assign wr_cfg    = data_write && (address >= ADDR_COEF0) && (address <= ADDR_SHIFT);
    assign clr       = wr_ctrl && data_in[CTRL_CLR];
    assign coef_idx  = TapW'(address - ADDR_COEF0);

    // TRIG and divider tick in the same cycle merge into one tick; CLR suppresses both.
    assign div_tick = en_q && (cnt_q == div_q);
    assign tick     = div_tick || trig_q;
    assign tick_go  = tick && !busy && !clr;
    assign tick_ovr = tick && busy && !clr;

    // Control and configuration registers; coefficient/shift writes are dropped while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            trig_q  <= 1'b0;
            div_q   <= RESET_DIV;
            shift_q <= '0;
            for (int unsigned i = 0; i < NTAPS; i++) coef_q[i] <= '0;
        end else begin
            trig_q <= wr_ctrl && data_in[CTRL_TRIG];
            if (wr_ctrl) en_q <= data_in[CTRL_EN];
            if (wr_div)  div_q <= data_in;
            if (wr_cfg && !busy) begin
                if (address == ADDR_SHIFT) shift_q <= data_in[2:0];
                else                       coef_q[coef_idx] <= data_in;
            end
        end
    end

    // Tick divider: restarts on a DIV write, after each tick, and while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en_q || wr_div || div_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // FSM state and tap index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tap_q   <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
        end
    end

    // Next-state: one tap per MAC cycle, then a single publish cycle.
    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        load_result = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick_go) begin
                    state_d = StMac;
                    tap_d   = '0;
                    mac_clr = 1'b1;
                end
            end
            StMac: begin
                mac_en = 1'b1;
                tap_d  = tap_q + 1'b1;
                if (tap_q == TapW'(NTAPS - 1)) state_d = StDone;
            end
            StDone: begin
                load_result = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (clr) begin
            state_d     = StIdle;
            tap_d       = '0;
            mac_clr     = 1'b1;
            mac_en      = 1'b0;
            load_result = 1'b0;
        end
    end

    // Sample history, newest in slot 0; an overrun tick does not shift it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NTAPS; i++) hist_q[i] <= '0;
        end else if (clr) begin
            for (int unsigned i = 0; i < NTAPS; i++) hist_q[i] <= '0;
        end else if (tick_go) begin
            hist_q[0] <= ui_in;
            for (int unsigned i = 1; i < NTAPS; i++) hist_q[i] <= hist_q[i-1];
        end
    end

    tqvp_fir_seq_mac u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (mac_clr),
        .acc_en (mac_en),
        .sample (hist_q[tap_q]),
        .coef   (coef_q[tap_q]),
        .acc    (acc)
    );

`ifdef TQVP_FIR_SEQ_SATURATE_EN
    logic signed [ACC_W-1:0] acc_sh;
    assign acc_sh = acc >>> shift_q;

    // Clamp the shifted accumulator into the unsigned byte range.
    always_comb begin
        if (acc_sh[ACC_W-1])          result_d = 8'h00;
        else if (|acc_sh[ACC_W-2:8])  result_d = 8'hFF;
        else                          result_d = acc_sh[7:0];
    end
`else
    assign result_d = 8'(acc >>> shift_q);
`endif

    // RESULT register; kept across CLR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else if (load_result) begin
            result_q <= result_d;
        end
    end

    // Sticky flags: a STATUS write clears them, but a same-cycle set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            werr_q  <= 1'b0;
        end else if (clr) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            if (wr_status) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
                werr_q  <= 1'b0;
            end
            if (load_result)     valid_q <= 1'b1;
            if (tick_ovr)        ovr_q   <= 1'b1;
            if (wr_cfg && busy)  werr_q  <= 1'b1;
        end
    end

    // STATUS assembly.
    always_comb begin
        status             = '0;
        status[STAT_BUSY]  = busy;
        status[STAT_VALID] = valid_q;
        status[STAT_OVR]   = ovr_q;
        status[STAT_WERR]  = werr_q;
    end

    // Combinational read mux.
    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_CTRL:   data_out = {7'b0, en_q};
            ADDR_DIV:    data_out = div_q;
            ADDR_COEF0:  data_out = coef_q[0];
            ADDR_COEF1:  data_out = coef_q[1];
            ADDR_COEF2:  data_out = coef_q[2];
            ADDR_COEF3:  data_out = coef_q[3];
            ADDR_SHIFT:  data_out = {5'b0, shift_q};
            ADDR_RESULT: data_out = result_q;
            ADDR_STATUS: data_out = status;
            default:     data_out = 8'h00;
        endcase
    end

    assign uo_out = result_q;

endmodule

// File: tb/tb_tqvp_fir_seq.sv
// Directed + randomized bench for tqvp_fir_seq against a sum-of-products reference model.
module tb_tqvp_fir_seq;

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_DIV    = 4'h1;
    localparam logic [3:0] A_COEF0  = 4'h2;
    localparam logic [3:0] A_SHIFT  = 4'h6;
    localparam logic [3:0] A_RESULT = 4'h7;
    localparam logic [3:0] A_STATUS = 4'h8;

`ifdef TQVP_FIR_SEQ_SATURATE_EN
    localparam logic [7:0] EXP_OVF = 8'hFF;
    localparam logic [7:0] EXP_NEG = 8'h00;
`else
    localparam logic [7:0] EXP_OVF = 8'h81;
    localparam logic [7:0] EXP_NEG = 8'hF6;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    logic [7:0] m_hist [4];
    logic [7:0] m_coef [4];
    logic [2:0] m_shift;
    logic [7:0] m_result;

    tqvp_fir_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always #8 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        step(1);
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        address = a;
        #1;
        v = data_out;
    endtask

    function automatic logic [3:0] coef_addr(input int i);
        return 4'(int'(A_COEF0) + i);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = 8'h00;
            m_coef[i] = 8'h00;
        end
        m_shift  = 3'd0;
        m_result = 8'h00;
    endtask

    task automatic model_tick(input logic [7:0] v);
        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = v;
    endtask

    // Plain integer FIR: sum of unsigned sample times signed coefficient, shifted, then narrowed.
    function automatic logic [7:0] model_eval();
        int s = 0;
        for (int i = 0; i < 4; i++) s += int'(m_hist[i]) * int'($signed(m_coef[i]));
        s = s >>> m_shift;
`ifdef TQVP_FIR_SEQ_SATURATE_EN
        if (s < 0) return 8'h00;
        if (s > 255) return 8'hFF;
        return 8'(s);
`else
        return 8'(s);
`endif
    endfunction

    // TRIG write, then check RESULT is unchanged one cycle before and updated 5 cycles after tick.
    task automatic do_trig(input logic [7:0] v, input string tag);
        logic [7:0] exp;
        logic [7:0] r;
        ui_in = v;
        wr(A_CTRL, 8'h02);
        model_tick(v);
        exp = model_eval();
        step(5);
        check({tag, "_pre"}, uo_out, m_result);
        rd(A_STATUS, r);
        check({tag, "_busy"}, r & 8'h01, 8'h01);
        step(1);
        check({tag, "_uo"}, uo_out, exp);
        rd(A_RESULT, r);
        check({tag, "_reg"}, r, exp);
        rd(A_STATUS, r);
        check({tag, "_valid"}, r & 8'h03, 8'h02);
        m_result = exp;
    endtask

    initial begin
        logic [7:0] r;
        int last_acc;
        int cyc;

        model_reset();
        step(3);
        check("rst_uo", uo_out, 8'h00);
        rd(A_DIV, r);    check("rst_div", r, 8'd63);
        rd(A_STATUS, r); check("rst_status", r, 8'h00);
        rd(A_CTRL, r);   check("rst_ctrl", r, 8'h00);
        rst_n = 1'b1;
        step(1);

        // Averaging
        for (int i = 0; i < 4; i++) begin
            wr(coef_addr(i), 8'd1);
            m_coef[i] = 8'd1;
        end
        wr(A_SHIFT, 8'd2);
        m_shift = 3'd2;
        for (int k = 1; k <= 4; k++) do_trig(8'(4 * k), "avg");
        check("avg_final", uo_out, 8'd10);

        // Overflow and negative
        wr(A_COEF0, 8'd127);
        m_coef[0] = 8'd127;
        for (int i = 1; i < 4; i++) begin
            wr(coef_addr(i), 8'd0);
            m_coef[i] = 8'd0;
        end
        wr(A_SHIFT, 8'd0);
        m_shift = 3'd0;
        do_trig(8'd255, "ovf");
        check("ovf_const", uo_out, EXP_OVF);
        wr(A_COEF0, 8'hFF);
        m_coef[0] = 8'hFF;
        do_trig(8'd10, "neg");
        check("neg_const", uo_out, EXP_NEG);

        // Coefficient write while busy is dropped and flags WERR
        wr(A_STATUS, 8'h00);
        ui_in = 8'd50;
        wr(A_CTRL, 8'h02);
        model_tick(8'd50);
        step(1);
        wr(coef_addr(1), 8'h5A);
        rd(A_STATUS, r);
        check("werr", r & 8'h08, 8'h08);
        rd(coef_addr(1), r);
        check("coef1_kept", r, m_coef[1]);
        step(4);
        check("busy_wr_res", uo_out, model_eval());
        m_result = model_eval();

        // CLR during MAC
        wr(A_STATUS, 8'h00);
        ui_in = 8'd60;
        wr(A_CTRL, 8'h02);
        step(2);
        wr(A_CTRL, 8'h04);
        for (int i = 0; i < 4; i++) m_hist[i] = 8'h00;
        rd(A_STATUS, r);
        check("clr_status", r, 8'h00);
        check("clr_uo_kept", uo_out, m_result);
        step(6);
        check("clr_no_publish", uo_out, m_result);
        for (int i = 0; i < 4; i++) begin
            wr(coef_addr(i), 8'd1);
            m_coef[i] = 8'd1;
        end
        do_trig(8'd7, "post_clr");
        check("post_clr_const", uo_out, 8'd7);

        // Overrun with DIV=2: ticks every 3 cycles, every other one dropped
        m_coef[0] = 8'd1; m_coef[1] = 8'd2; m_coef[2] = 8'd4; m_coef[3] = 8'd8;
        for (int i = 0; i < 4; i++) wr(coef_addr(i), m_coef[i]);
        wr(A_STATUS, 8'h00);
        wr(A_DIV, 8'd2);
        wr(A_CTRL, 8'h01);
        address  = A_STATUS;
        last_acc = -100;
        for (int k = 1; k <= 18; k++) begin
            ui_in = 8'(20 + k);
            if (k == 18) wr(A_CTRL, 8'h00);
            else step(1);
            if (k % 3 == 0 && k - last_acc >= 6) begin
                model_tick(ui_in);
                last_acc = k;
            end
            if (k == 5) check("ovr_pre", data_out & 8'h04, 8'h00);
            if (k == 6) check("ovr_set", data_out & 8'h04, 8'h04);
        end
        step(3);
        check("ovr_res", uo_out, model_eval());
        m_result = model_eval();
        rd(A_STATUS, r);
        check("ovr_sticky", r & 8'h04, 8'h04);
        wr(A_STATUS, 8'hFF);
        rd(A_STATUS, r);
        check("status_clr", r, 8'h00);

        // Randomized coefficients, shift and samples
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 4; i++) begin
                m_coef[i] = 8'($urandom);
                wr(coef_addr(i), m_coef[i]);
            end
            r = 8'($urandom);
            m_shift = r[2:0];
            wr(A_SHIFT, r);
            rd(A_SHIFT, r);
            check("shift_rd", r, {5'b0, m_shift});
            do_trig(8'($urandom), "rand_a");
            do_trig(8'($urandom), "rand_b");
        end

        // Reset mid-MAC, then first divider tick timing
        ui_in = 8'd99;
        wr(A_CTRL, 8'h02);
        step(2);
        #2 rst_n = 1'b0;
        #1;
        check("rstm_uo", uo_out, 8'h00);
        rd(A_DIV, r);    check("rstm_div", r, 8'd63);
        rd(A_STATUS, r); check("rstm_status", r, 8'h00);
        rd(A_RESULT, r); check("rstm_result", r, 8'h00);
        rd(A_SHIFT, r);  check("rstm_shift", r, 8'h00);
        step(2);
        rst_n = 1'b1;
        model_reset();
        step(1);
        wr(A_CTRL, 8'h01);
        address = A_STATUS;
        cyc = 0;
        while (cyc < 200) begin
            step(1);
            cyc++;
            if (data_out[0]) break;
        end
        check("first_tick", 8'(cyc), 8'd64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/tqvp_fir_seq.md
# tqvp_fir_seq

Register-programmable FIR sequencer for the TinyQV byte-peripheral slot. It generates sample ticks from a programmable divider or from a CPU trigger, and captures `ui_in` into a 4-deep sample history on each tick. A single shared multiply-accumulate datapath then runs the 4 taps in sequence against CPU-written signed coefficients. The scaled result is published on `uo_out` and in a readable register.

## Interface
- `NTAPS`, 4: number of taps, fixed at 4 by the register map.
- `RESET_DIV`, 8'd63: reset value of the DIV register.
- `clk` in 1: project clock, 64 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ui_in` in 8: input PMOD. The unsigned sample source, already synchronised.
- `uo_out` out 8: RESULT register, driven continuously.
- `address` in 4: register select.
- `data_write` in 1: write strobe, one cycle.
- `data_in` in 8: write data.
- `data_out` out 8: read data, combinational from `address`.

## Operation
Register map (unlisted addresses read 0; writes to them are ignored):
- 0x0 CTRL
  - bit0 EN: continuous sampling.
  - bit1 TRIG: write 1 for one tick; self-clearing, reads 0.
  - bit2 CLR: write 1 to clear; self-clearing, reads 0.
- 0x1 DIV: when EN=1, a tick occurs every DIV+1 cycles. A write to DIV, or EN=0, zeroes the divider counter.
- 0x2–0x5 COEF0..COEF3: signed 8-bit coefficients. COEF0 applies to the newest sample.
- 0x6 SHIFT: bits[2:0] set the arithmetic right shift applied to the accumulator; bits[7:3] read 0.
- 0x7 RESULT: 8-bit output.
- 0x8 STATUS
  - bit0 BUSY
  - bit1 VALID
  - bit2 OVR
  - bit3 WERR
  - Any write to 0x8 clears VALID, OVR and WERR.

FSM states are IDLE, MAC and DONE:
- IDLE, on a tick: shift history (s3←s2, s2←s1, s1←s0, s0←`ui_in`), set acc←0 and tap←0, go to MAC.
- MAC, one tap per cycle: acc += s[tap] × COEF[tap]. The sample is zero-extended to 9 bits before the signed 9×8 multiply. acc is 18-bit signed. After tap 3, go to DONE.
- DONE: RESULT ← truncate_or_saturate(acc >>> SHIFT), VALID←1, go to IDLE.

Boundary rules:
- Tick while BUSY (state ≠ IDLE): the tick is dropped, OVR←1, and the history is not shifted.
- TRIG and a divider tick in the same cycle count as one tick.
- Writes to 0x2–0x6 while BUSY are dropped and set WERR. CTRL and DIV writes are always accepted.
- CLR (any state) zeroes the history, acc, VALID, OVR and WERR, and returns the FSM to IDLE. RESULT is kept. CLR has priority over a same-cycle tick.
- A flag set and a STATUS write in the same cycle: the set wins.

Reset values:
- All registers, history, acc and the counter are 0.
- DIV = RESET_DIV.
- FSM is IDLE.
- `uo_out` = 0.

## Timing
- The tick is sampled at edge N, when `ui_in` is captured.
- MAC runs at edges N+1..N+4 and DONE at N+5. RESULT, `uo_out` and VALID update at edge N+5.
- BUSY is high from after edge N until edge N+5.
- The minimum tick spacing without overrun is 6 cycles, so DIV ≥ 5.
- A register write takes effect at the next edge. A TRIG write at edge W produces its tick at edge W+1.
- Read data is combinational. BUSY and STATUS reflect the current state.

## Configuration
- `TQVP_FIR_SEQ_SATURATE_EN` defined: the shifted accumulator is clamped to 0..255. Negative values give 0; values above 255 give 255.
- Not defined: RESULT is bits[7:0] of the shifted accumulator, two's-complement truncation.

## Structure
- Package `tqvp_fir_seq_pkg` holds:
  - register address constants;
  - CTRL and STATUS bit indices;
  - the FSM state enum;
  - `ACC_W` = 18;
  - `NTAPS`.
- Sub-module `tqvp_fir_seq_mac`: the shared multiplier and accumulator. It has clear and accumulate-enable inputs, sample and coefficient inputs, and an 18-bit acc output.

## Test plan
- Averaging: COEF0..3 = 1, SHIFT = 2, four TRIGs with `ui_in` = 4, 8, 12, 16 → RESULT and `uo_out` = 10 and VALID = 1, each RESULT update 5 cycles after its trigger tick.
- Overflow: COEF0 = 127, others 0, SHIFT = 0, TRIG with `ui_in` = 255 → 255 with SATURATE_EN; 0x81 without it.
- Negative: COEF0 = 0xFF (−1), SHIFT = 0, TRIG with `ui_in` = 10 → 0 with SATURATE_EN; 0xF6 without it.
- Overrun: DIV = 2, EN = 1 → OVR sets by the second tick, and the history holds only every other sample. A write to 0x8 clears OVR.
- Busy write and CLR:
  - Write COEF1 one cycle after TRIG → WERR = 1 and COEF1 unchanged.
  - CLR during MAC → BUSY = 0 next cycle, RESULT unchanged, history zero.
- Reset: assert `rst_n` low mid-MAC → all outputs 0 and DIV reads 63; EN = 1 after release gives a first tick 64 cycles later.
